// File: rtl/uart_pkg.sv
// Shared UART constants and receive FSM encoding, used by both the
// receive-to-memory path and the result transmit path.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int MAT_DIM          = 3;
  localparam int DEPTH_DEF        = 2 * MAT_DIM * MAT_DIM;
  localparam int ADDR_W_DEF       = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WRITE,
    ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and
// LSB-first shift register. byte_valid strobes on the good stop-bit sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             ferr_nx;
  logic             sync_p0, sync_p1;
  logic             rx_s;

  assign rx_s = sync_p1;

  // Synchroniser: idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx_data;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_nx;
      frame_err <= ferr_nx;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_nx     = bit_idx;
    shreg_nx   = shreg;
    ferr_nx    = 1'b0;
    byte_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        bit_nx = '0;
        if (!rx_s) state_nx = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          state_nx = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[7:1]};
          bit_nx   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            byte_valid = 1'b1;
            state_nx   = ST_WRITE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = ST_WAIT_IDLE;
          end
        end
      end
      ST_WRITE: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        cnt_nx = '0;
        if (rx_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign byte_data = shreg;
  assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/rx_to_mem.sv
// Writes received UART bytes sequentially into operand memory and flags
// completion once DEPTH bytes have landed.
module rx_to_mem
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  input  logic              start_load,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              load_done,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              armed;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              do_write;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // A coincident start_load re-arms first, so the byte lands at address 0
  always_comb begin
    wr_addr  = start_load ? '0 : addr_cnt;
    do_write = byte_valid && (armed || start_load);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
      armed     <= 1'b0;
      addr_cnt  <= '0;
    end else begin
      mem_we    <= do_write;
      mem_addr  <= do_write ? wr_addr : '0;
      mem_wdata <= do_write ? byte_data : 8'h00;
      if (start_load) begin
        armed     <= 1'b1;
        addr_cnt  <= '0;
        load_done <= 1'b0;
      end
      if (do_write) begin
        if (wr_addr == LAST_ADDR) begin
          load_done <= 1'b1;
          armed     <= 1'b0;
          addr_cnt  <= wr_addr;
        end else begin
          addr_cnt <= wr_addr + 1'b1;
        end
      end
    end
  end

endmodule
